phy_tx_arbiter: RTL and testbench
=================================

Name: phy_tx_arbiter

Overview:
- Shares one phy_module TX AXI-stream slave port among P_NUM_SRC packet sources.
- Grants are round-robin and switch only at packet boundaries, so packets never interleave.
- New grants are gated by the GT TX-ready indication.
- Sits in the GT TX user-clock domain, between user logic and phy_module's i_axi_s_* port. One instance per lane.

Parameters:
- P_NUM_SRC, 2, number of requesting sources (legal 2..8).
- P_DATA_WIDTH, 32, AXI-stream data width in bits.
- P_KEEP_WIDTH, 4, AXI-stream keep width (P_DATA_WIDTH/8).

Ports:
- i_clk  in  1  GT TX user clock (o_tx*_clk of gt_module).
- i_rst  in  1  synchronous, active-high reset.
- i_link_up  in  1  GT TX done, already synchronous to i_clk; high = new packets may start.
- i_s_valid  in  P_NUM_SRC  per-source tvalid.
- i_s_data  in  P_NUM_SRC*P_DATA_WIDTH  per-source tdata, source k at bits [k*P_DATA_WIDTH +: P_DATA_WIDTH].
- i_s_keep  in  P_NUM_SRC*P_KEEP_WIDTH  per-source tkeep, packed the same way.
- i_s_last  in  P_NUM_SRC  per-source tlast.
- o_s_ready  out  P_NUM_SRC  per-source tready.
- o_m_valid  out  1  to phy i_axi_s_valid.
- o_m_data  out  P_DATA_WIDTH  to phy i_axi_s_data.
- o_m_keep  out  P_KEEP_WIDTH  to phy i_axi_s_keep.
- o_m_last  out  1  to phy i_axi_s_last.
- i_m_ready  in  1  from phy o_axi_s_ready.
- o_grant  out  P_NUM_SRC  one-hot current grant; all zero when idle.
- o_busy  out  1  high while a packet is in flight.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values:
  - Registered state returns to IDLE.
  - o_grant = 0, o_busy = 0, o_s_ready = 0, o_m_valid = 0, o_m_last = 0.
  - o_m_data and o_m_keep = 0.
  - Round-robin pointer r_last = P_NUM_SRC-1, so source 0 has highest priority first.
- States:
  - IDLE: no grant.
  - XFER: one source granted.
- IDLE -> XFER:
  - Condition: i_link_up=1 and any i_s_valid bit is set.
  - Winner is the first requesting index scanning r_last+1, r_last+2, ... modulo P_NUM_SRC.
  - Registered into o_grant and r_last on the same edge; o_busy=1 from the next cycle.
  - Arbitration latency: 1 cycle from valid to grant. No output beat in the decision cycle.
- XFER datapath, combinational from the granted source:
  - o_m_valid/data/keep/last = granted source's signals.
  - o_s_ready[g] = i_m_ready; all other o_s_ready bits = 0.
  - When not in XFER, o_m_* are driven to 0.
- A beat transfers when o_m_valid & i_m_ready. Data, keep and valid are never altered.
- XFER -> IDLE: on the beat with o_m_last=1. o_grant clears on that edge. One idle cycle minimum between packets.
- Grant is held through source valid gaps mid-packet. No timeout; the arbiter waits for last.
- i_link_up falling mid-packet: the current packet continues to last (phy ready governs). No new grant until i_link_up=1.
- Simultaneous requests: only round-robin order decides. A source that keeps requesting is served at most P_NUM_SRC-1 packets after it raises valid.
- Single-beat packet (valid+last on the first beat): XFER lasts 1 cycle if i_m_ready=1.
- i_rst mid-packet: drop to IDLE next edge. The partial packet is truncated downstream; the upstream phy reset is co-asserted by rst_gen.

Decomposition:
- Shared package phy_pkg holds:
  - AXI width constants (32/4).
  - The state encoding (IDLE=1'b0, XFER=1'b1).
  - A function rr_pick(req, last) returning the one-hot winner.
- No sub-module is needed. The round-robin picker is the rr_pick function, reused by future RX-side schedulers.

Test Plan:
- Reset release with i_s_valid=2'b11, i_link_up=1 -> o_grant=2'b01 one cycle after reset deassert; src0 4-beat packet passes verbatim; then o_grant=2'b10 after one idle cycle.
- Both sources stream back-to-back 3-beat packets continuously -> grant alternates 01,10,01,...; each packet is 3 beats + 1 idle cycle; no beat ever carries the wrong source's data.
- i_link_up=0 with src1 valid -> o_grant stays 0 and o_s_ready=0 for 20 cycles; raise i_link_up -> grant 10 on the next edge.
- i_m_ready toggling 1010... during a 5-beat src0 packet -> exactly 5 transfers; o_s_ready[0] mirrors i_m_ready; o_s_ready[1]=0 throughout.
- i_link_up drops at beat 2 of 6 -> all 6 beats delivered, then IDLE with no further grant while low.
- Assert i_rst at beat 3 of a packet -> next cycle o_grant=0, o_m_valid=0, r_last=P_NUM_SRC-1 (src0 wins the next arbitration).

Source files
------------

// File: rtl/phy_pkg.sv
// phy_pkg
//   Shared definitions for the PHY-side stream schedulers.
//   - AXI-stream width constants for the phy_module user port.
//   - Arbiter state encoding.
//   - rr_pick: round-robin winner selection, sized for up to RR_MAX_SRC
//     requesters so TX and RX schedulers can share one implementation.
package phy_pkg;

  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_KEEP_WIDTH = 4;
  localparam int RR_MAX_SRC     = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

  // Returns a one-hot winner among the lowest n request bits, scanning
  // last+1, last+2, ... modulo n. Returns zero when nothing requests.
  // Callers must pass 1 <= n <= RR_MAX_SRC.
  function automatic logic [RR_MAX_SRC-1:0] rr_pick(
    input logic [RR_MAX_SRC-1:0] req,
    input logic [2:0]            last,
    input int unsigned           n
  );
    logic [RR_MAX_SRC-1:0] win;
    logic [2:0]            idx;
    win = '0;
    for (int unsigned i = 1; i <= RR_MAX_SRC; i++) begin
      idx = 3'((32'(last) + i) % n);
      if ((i <= n) && (win == '0) && req[idx]) begin
        win[idx] = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/phy_tx_arbiter.sv
// phy_tx_arbiter
//   Shares one phy_module TX AXI-stream slave port among P_NUM_SRC
//   packet sources. Round-robin grants change only at packet boundaries,
//   and new grants wait for i_link_up. One instance per lane, clocked by
//   the GT TX user clock.
//
// Ports
//   i_clk, i_rst          GT TX user clock, synchronous active-high reset
//   i_link_up             GT TX done (synchronous); gates new grants only
//   i_s_valid/data/keep/last, o_s_ready
//                         per-source AXI-stream slave ports, source k at
//                         slice k of each packed bus
//   o_m_valid/data/keep/last, i_m_ready
//                         AXI-stream master toward phy i_axi_s_*
//   o_grant               one-hot current grant, zero when idle
//   o_busy                high while a packet is in flight
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no grant; arbitrate when link is up and any source is valid
// ST_XFER | one source owns the master port until its last beat moves
module phy_tx_arbiter
  import phy_pkg::*;
#(
  parameter int P_NUM_SRC    = 2,
  parameter int P_DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int P_KEEP_WIDTH = AXI_KEEP_WIDTH
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_link_up,
  input  logic [P_NUM_SRC-1:0]              i_s_valid,
  input  logic [P_NUM_SRC*P_DATA_WIDTH-1:0] i_s_data,
  input  logic [P_NUM_SRC*P_KEEP_WIDTH-1:0] i_s_keep,
  input  logic [P_NUM_SRC-1:0]              i_s_last,
  output logic [P_NUM_SRC-1:0]              o_s_ready,
  output logic                              o_m_valid,
  output logic [P_DATA_WIDTH-1:0]           o_m_data,
  output logic [P_KEEP_WIDTH-1:0]           o_m_keep,
  output logic                              o_m_last,
  input  logic                              i_m_ready,
  output logic [P_NUM_SRC-1:0]              o_grant,
  output logic                              o_busy
);

  localparam int IDX_W = $clog2(P_NUM_SRC);

  arb_state_t           state_q, state_d;
  logic [P_NUM_SRC-1:0] grant_q, grant_d;
  // r_last doubles as the granted index while in ST_XFER, since the
  // winner is written to both on the same edge.
  logic [IDX_W-1:0]     r_last_q, r_last_d;
  logic [P_NUM_SRC-1:0] pick;
  logic [IDX_W-1:0]     pick_idx;

  assign pick = P_NUM_SRC'(rr_pick(RR_MAX_SRC'(i_s_valid), 3'(r_last_q), P_NUM_SRC));

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < P_NUM_SRC; i++) begin
      if (pick[i]) begin
        pick_idx = IDX_W'(i);
      end
    end
  end

  // Master-side mux and ready steering; everything is zero outside XFER.
  always_comb begin
    o_m_valid = 1'b0;
    o_m_data  = '0;
    o_m_keep  = '0;
    o_m_last  = 1'b0;
    o_s_ready = '0;
    if (state_q == ST_XFER) begin
      o_m_valid           = i_s_valid[r_last_q];
      o_m_data            = i_s_data[r_last_q*P_DATA_WIDTH +: P_DATA_WIDTH];
      o_m_keep            = i_s_keep[r_last_q*P_KEEP_WIDTH +: P_KEEP_WIDTH];
      o_m_last            = i_s_last[r_last_q];
      o_s_ready[r_last_q] = i_m_ready;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    r_last_d = r_last_q;
    case (state_q)
      ST_IDLE: begin
        if (i_link_up && (|i_s_valid)) begin
          state_d  = ST_XFER;
          grant_d  = pick;
          r_last_d = pick_idx;
        end
      end
      ST_XFER: begin
        // Link loss does not abort a packet; only the last beat ends it.
        if (o_m_valid && i_m_ready && o_m_last) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      r_last_q <= IDX_W'(P_NUM_SRC - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      r_last_q <= r_last_d;
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q == ST_XFER);

endmodule

// File: tb/tb_phy_tx_arbiter.sv
module tb_phy_tx_arbiter;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int KW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, link_up;
  logic [N-1:0]    s_valid, s_last, s_ready, grant;
  logic [N*DW-1:0] s_data;
  logic [N*KW-1:0] s_keep;
  logic            m_valid, m_last, m_ready, busy;
  logic [DW-1:0]   m_data;
  logic [KW-1:0]   m_keep;

  phy_tx_arbiter #(.P_NUM_SRC(N), .P_DATA_WIDTH(DW), .P_KEEP_WIDTH(KW)) dut (
    .i_clk(clk), .i_rst(rst), .i_link_up(link_up),
    .i_s_valid(s_valid), .i_s_data(s_data), .i_s_keep(s_keep), .i_s_last(s_last),
    .o_s_ready(s_ready),
    .o_m_valid(m_valid), .o_m_data(m_data), .o_m_keep(m_keep), .o_m_last(m_last),
    .i_m_ready(m_ready), .o_grant(grant), .o_busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- source generators + reference model ----------------
  int len[N], beat[N], pktno[N], left[N], fixlen[N], xfers[N];
  int vprob = 100, rprob = 100, rmode = 0, cyc = 0;
  int owner = -1;      // source currently owning the port, -1 = none
  int rr = N - 1;      // most recently granted source
  int dut_beats = 0;

  function automatic logic [DW-1:0] mkdata(input int k, input int p, input int b);
    return {4'(k + 1), 12'(p), 16'(b + 16'h5a00)};
  endfunction

  task automatic new_pkt(input int k);
    beat[k] = 0;
    len[k]  = (fixlen[k] > 0) ? fixlen[k] : int'($urandom_range(1, 5));
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      s_valid[k]            = (left[k] != 0) && (int'($urandom_range(0, 99)) < vprob);
      s_data[k*DW +: DW]    = mkdata(k, pktno[k], beat[k]);
      s_last[k]             = (beat[k] == len[k] - 1);
      s_keep[k*KW +: KW]    = s_last[k] ? KW'((pktno[k] + k) % 15 + 1) : '1;
    end
    m_ready = (rmode == 1) ? (cyc % 2 == 0) : (int'($urandom_range(0, 99)) < rprob);
  endtask

  // Check outputs against the model, advance the model, clock, re-drive.
  task automatic step();
    logic [N-1:0] eg, er;
    logic         ev, el;
    logic [DW-1:0] ed;
    logic [KW-1:0] ek;
    #1;
    eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0; ek = '0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      ev = s_valid[owner];
      el = s_last[owner];
      ed = s_data[owner*DW +: DW];
      ek = s_keep[owner*KW +: KW];
      if (m_ready) er[owner] = 1'b1;
    end
    chk("grant", 64'(grant), 64'(eg));
    chk("busy", 64'(busy), 64'(owner >= 0));
    chk("m_valid", 64'(m_valid), 64'(ev));
    chk("m_last", 64'(m_last), 64'(el));
    chk("m_data", 64'(m_data), 64'(ed));
    chk("m_keep", 64'(m_keep), 64'(ek));
    chk("s_ready", 64'(s_ready), 64'(er));
    if (m_valid && m_ready) dut_beats++;
    if (owner >= 0) begin
      if (s_valid[owner] && m_ready) begin
        xfers[owner]++;
        if (s_last[owner]) begin
          pktno[owner]++;
          if (left[owner] > 0) left[owner]--;
          new_pkt(owner);
          owner = -1;
        end else begin
          beat[owner]++;
        end
      end
    end else if (link_up && (|s_valid)) begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (rr + i) % N;
        if (s_valid[c]) begin
          owner = c;
          rr = c;
          break;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    drive();
  endtask

  // Holds reset two edges with stimulus already applied, then releases it
  // just after an edge so the next edge is the first arbitration edge.
  task automatic do_reset();
    rst = 1'b1;
    owner = -1; rr = N - 1; cyc = 0; dut_beats = 0;
    for (int k = 0; k < N; k++) begin
      pktno[k] = 0; xfers[k] = 0;
      new_pkt(k);
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       link;
    logic [1:0] valid;
    logic [1:0] last;
    logic       rdy;
    logic [1:0] grant;
    logic       mvalid;
    logic [1:0] ready;
  } vec_t;

  vec_t tbl[14];
  localparam logic [DW-1:0] D0 = 32'h0000_aaa0;
  localparam logic [DW-1:0] D1 = 32'h1111_bbb1;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    logic [1:0]    eg;
    logic [DW-1:0] ed;
    logic          el;

    tbl[0]  = '{1'b1, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};
    tbl[1]  = '{1'b1, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 2'b01};
    tbl[2]  = '{1'b1, 2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01};
    tbl[3]  = '{1'b1, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};
    tbl[4]  = '{1'b1, 2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 2'b00};
    tbl[5]  = '{1'b1, 2'b01, 2'b00, 1'b1, 2'b10, 1'b0, 2'b10};
    tbl[6]  = '{1'b1, 2'b11, 2'b10, 1'b1, 2'b10, 1'b1, 2'b10};
    tbl[7]  = '{1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};
    tbl[8]  = '{1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};
    tbl[9]  = '{1'b1, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};
    tbl[10] = '{1'b1, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 2'b01};
    tbl[11] = '{1'b1, 2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01};
    tbl[12] = '{1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};
    tbl[13] = '{1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};

    rst = 1'b1; link_up = 1'b0; s_valid = '0; s_last = '0; m_ready = 1'b0;
    s_data = {D1, D0}; s_keep = {4'hc, 4'h3};
    for (int k = 0; k < N; k++) begin
      left[k] = 0; fixlen[k] = 1; xfers[k] = 0; pktno[k] = 0; len[k] = 1; beat[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_grant", 64'(grant), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_mvalid", 64'(m_valid), 64'(0));
    chk("reset_mdata", 64'(m_data), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      link_up = tbl[i].link; s_valid = tbl[i].valid; s_last = tbl[i].last; m_ready = tbl[i].rdy;
      #1;
      eg = tbl[i].grant;
      ed = (eg == 2'b01) ? D0 : (eg == 2'b10) ? D1 : '0;
      el = (eg == 2'b01) ? tbl[i].last[0] : (eg == 2'b10) ? tbl[i].last[1] : 1'b0;
      chk($sformatf("tbl%0d_grant", i), 64'(grant), 64'(eg));
      chk($sformatf("tbl%0d_mvalid", i), 64'(m_valid), 64'(tbl[i].mvalid));
      chk($sformatf("tbl%0d_ready", i), 64'(s_ready), 64'(tbl[i].ready));
      chk($sformatf("tbl%0d_mdata", i), 64'(m_data), 64'(ed));
      chk($sformatf("tbl%0d_mlast", i), 64'(m_last), 64'(el));
      @(posedge clk);
      #1;
    end

    // Reset release with both requesting: src0 4-beat packet, then src1.
    link_up = 1'b1; vprob = 100; rprob = 100; rmode = 0;
    fixlen[0] = 4; fixlen[1] = 3; left[0] = 1; left[1] = 1;
    do_reset();
    step();
    chk("rel_grant_src0", 64'(grant), 64'(2'b01));
    for (int t = 0; t < 20 && owner != -1; t++) step();
    chk("rel_src0_beats", 64'(dut_beats), 64'(4));
    step();
    chk("rel_grant_src1", 64'(grant), 64'(2'b10));

    // Back-to-back 3-beat packets: 3 grant cycles + 1 idle, alternating.
    fixlen[0] = 3; fixlen[1] = 3; left[0] = -1; left[1] = -1;
    do_reset();
    step();
    for (int t = 1; t <= 32; t++) begin
      int ph;
      ph = (t - 1) % 8;
      #1;
      eg = (ph < 3) ? 2'b01 : (ph == 3 || ph == 7) ? 2'b00 : 2'b10;
      chk($sformatf("alt%0d_grant", t), 64'(grant), 64'(eg));
      step();
    end

    // Link down: requests pending but no grant until link comes up.
    link_up = 1'b0; fixlen[1] = 2; left[0] = 0; left[1] = 1;
    do_reset();
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (grant !== 2'b00 || s_ready !== 2'b00) bad++;
      step();
    end
    chk("link_low_hold", 64'(bad), 64'(0));
    link_up = 1'b1;
    step();
    chk("link_up_grant", 64'(grant), 64'(2'b10));
    for (int t = 0; t < 10 && owner != -1; t++) step();

    // Toggling downstream ready during a 5-beat src0 packet.
    fixlen[0] = 5; left[0] = 1; left[1] = 0; rmode = 1;
    do_reset();
    bad = 0;
    for (int t = 0; t < 40 && !(t > 0 && owner == -1 && dut_beats >= 5); t++) begin
      #1;
      if (grant === 2'b01 && s_ready[0] !== m_ready) bad++;
      if (s_ready[1] !== 1'b0) bad++;
      step();
    end
    chk("toggle_beats", 64'(dut_beats), 64'(5));
    chk("toggle_ready_mirror", 64'(bad), 64'(0));
    rmode = 0;

    // Link drops at beat 2 of 6: packet completes, then no new grant.
    link_up = 1'b1; fixlen[0] = 6; fixlen[1] = 2; left[0] = 1; left[1] = 1;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      step();
      if (owner == 0 && beat[0] == 2) link_up = 1'b0;
      if (owner == -1) break;
    end
    chk("drop_beats", 64'(dut_beats), 64'(6));
    bad = 0;
    for (int t = 0; t < 6; t++) begin
      #1;
      if (grant !== 2'b00) bad++;
      step();
    end
    chk("drop_no_grant", 64'(bad), 64'(0));
    link_up = 1'b1;
    step();
    chk("drop_regrant", 64'(grant), 64'(2'b10));
    for (int t = 0; t < 10 && owner != -1; t++) step();

    // Reset at beat 3: idle next cycle, pointer back so src0 wins next.
    fixlen[0] = 6; left[0] = 1; left[1] = 0;
    do_reset();
    for (int t = 0; t < 20; t++) begin
      step();
      if (owner == 0 && beat[0] == 2) break;
    end
    chk("rstmid_in_pkt", 64'(grant), 64'(2'b01));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_grant", 64'(grant), 64'(0));
    chk("rstmid_mvalid", 64'(m_valid), 64'(0));
    chk("rstmid_busy", 64'(busy), 64'(0));
    chk("rstmid_ready", 64'(s_ready), 64'(0));
    rst = 1'b0;
    owner = -1; rr = N - 1;
    fixlen[0] = 2; fixlen[1] = 2; left[0] = 1; left[1] = 1;
    for (int k = 0; k < N; k++) new_pkt(k);
    drive();
    step();
    chk("rstmid_src0_wins", 64'(grant), 64'(2'b01));
    for (int t = 0; t < 10 && owner != -1; t++) step();

    // Randomized traffic against the model.
    fixlen[0] = 0; fixlen[1] = 0; left[0] = -1; left[1] = -1;
    vprob = 70; rprob = 70; link_up = 1'b1;
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 99) < 3) link_up = ~link_up;
      step();
    end
    chk("rand_progress", 64'(dut_beats > 200), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
